// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and address-field helpers for the set-associative data cache
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    function automatic int calc_offset_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    function automatic int calc_index_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int calc_tag_w(input int addr_w, input int sets, input int line_w);
        return addr_w - calc_index_w(sets) - calc_offset_w(line_w);
    endfunction

    // Field helpers work on a 64-bit container; callers cast to their own widths.
    function automatic logic [63:0] addr_index(input logic [63:0] addr, input int offset_w,
                                               input int index_w);
        return (addr >> offset_w) & ((64'd1 << index_w) - 64'd1);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] addr, input int offset_w,
                                             input int index_w);
        return addr >> (offset_w + index_w);
    endfunction

    function automatic logic [63:0] line_addr(input logic [63:0] tag, input logic [63:0] index,
                                              input int offset_w, input int index_w);
        return (tag << (offset_w + index_w)) | (index << offset_w);
    endfunction

endpackage

// File: rtl/dcache_way_array.sv
// rtl/dcache_way_array.sv - one cache way: tag/valid/dirty/data storage with async read
module dcache_way_array #(
    parameter int SETS    = 16,
    parameter int INDEX_W = 4,
    parameter int TAG_W   = 23,
    parameter int LINE_W  = 256,
    parameter int WORD_W  = 32,
    parameter int WSEL_W  = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [INDEX_W-1:0] index_i,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o,
    input  logic              word_we_i,
    input  logic [WSEL_W-1:0] word_sel_i,
    input  logic [WORD_W-1:0] word_data_i,
    input  logic              fill_we_i,
    input  logic [TAG_W-1:0]  fill_tag_i,
    input  logic [LINE_W-1:0] fill_data_i
);

    logic [SETS-1:0]   valid_q;
    logic [SETS-1:0]   dirty_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [LINE_W-1:0] data_q [SETS];

    assign valid_o = valid_q[index_i];
    assign dirty_o = dirty_q[index_i];
    assign tag_o   = tag_q[index_i];
    assign line_o  = data_q[index_i];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we_i) begin
            valid_q[index_i] <= 1'b1;
            dirty_q[index_i] <= 1'b0;
        end else if (word_we_i) begin
            dirty_q[index_i] <= 1'b1;
        end
    end

    // Payload storage is deliberately left out of reset; valid bits guard it.
    always_ff @(posedge clk_i) begin
        if (fill_we_i) begin
            tag_q[index_i]  <= fill_tag_i;
            data_q[index_i] <= fill_data_i;
        end else if (word_we_i) begin
            data_q[index_i][int'(word_sel_i)*WORD_W +: WORD_W] <= word_data_i;
        end
    end

endmodule

// File: rtl/dcache_assoc_ctrl.sv
// rtl/dcache_assoc_ctrl.sv - N-way set-associative write-back data cache controller
module dcache_assoc_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int WORD_W = 32,
    parameter int LINE_W = 256,
    parameter int SETS   = 16,
    parameter int WAYS   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [WORD_W-1:0] p1_data_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [WORD_W-1:0] p1_data_o,
    output logic              p1_stall_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o
);

    localparam int OFFSET_W = calc_offset_w(LINE_W);
    localparam int INDEX_W  = calc_index_w(SETS);
    localparam int TAG_W    = calc_tag_w(ADDR_W, SETS, LINE_W);
    localparam int WSEL_W   = $clog2(LINE_W / WORD_W);
    localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

    state_t state_q, state_n;

    logic               req;
    logic [INDEX_W-1:0] req_index;
    logic [TAG_W-1:0]   req_tag;
    logic [WSEL_W-1:0]  word_sel;

    logic [WAYS-1:0]    way_valid;
    logic [WAYS-1:0]    way_dirty;
    logic [TAG_W-1:0]   way_tag  [WAYS];
    logic [LINE_W-1:0]  way_line [WAYS];
    logic [WAYS-1:0]    way_word_we;
    logic [WAYS-1:0]    way_fill_we;

    logic               hit;
    logic [WAY_W-1:0]   hit_way;
    logic [LINE_W-1:0]  hit_line;
    logic               free_found;
    logic [WAY_W-1:0]   victim_sel;
    logic [WAY_W-1:0]   victim_q;
    logic [WAY_W-1:0]   rr_q [SETS];

    logic               miss;
    logic               word_we;
    logic               fill_we;

    assign req       = p1_MemRead_i | p1_MemWrite_i;
    assign req_index = INDEX_W'(addr_index(64'(p1_addr_i), OFFSET_W, INDEX_W));
    assign req_tag   = TAG_W'(addr_tag(64'(p1_addr_i), OFFSET_W, INDEX_W));
    assign word_sel  = p1_addr_i[OFFSET_W-1 -: WSEL_W];

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_word_we[w] = word_we && (hit_way == WAY_W'(w)) && !rst_i;
        assign way_fill_we[w] = fill_we && (victim_q == WAY_W'(w)) && !rst_i;

        dcache_way_array #(
            .SETS    (SETS),
            .INDEX_W (INDEX_W),
            .TAG_W   (TAG_W),
            .LINE_W  (LINE_W),
            .WORD_W  (WORD_W),
            .WSEL_W  (WSEL_W)
        ) u_way (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .index_i     (req_index),
            .valid_o     (way_valid[w]),
            .dirty_o     (way_dirty[w]),
            .tag_o       (way_tag[w]),
            .line_o      (way_line[w]),
            .word_we_i   (way_word_we[w]),
            .word_sel_i  (word_sel),
            .word_data_i (p1_data_i),
            .fill_we_i   (way_fill_we[w]),
            .fill_tag_i  (req_tag),
            .fill_data_i (mem_data_i)
        );
    end

    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_valid[w] && (way_tag[w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
        hit_line = way_line[hit_way];
    end

    // An empty way always wins over the round-robin choice.
    always_comb begin
        free_found = 1'b0;
        victim_sel = rr_q[req_index];
        for (int w = 0; w < WAYS; w++) begin
            if (!way_valid[w] && !free_found) begin
                free_found = 1'b1;
                victim_sel = WAY_W'(w);
            end
        end
    end

    always_comb begin
        state_n    = state_q;
        p1_stall_o = 1'b0;
        p1_data_o  = '0;
        word_we    = 1'b0;
        fill_we    = 1'b0;
        miss       = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        p1_data_o = hit_line[int'(word_sel)*WORD_W +: WORD_W];
                        word_we   = p1_MemWrite_i;
                    end else begin
                        p1_stall_o = 1'b1;
                        miss       = 1'b1;
                        state_n    = (way_valid[victim_sel] && way_dirty[victim_sel]) ?
                                     WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                p1_stall_o = 1'b1;
                if (mem_enable_o && mem_ack_i) begin
                    state_n = ALLOCATE;
                end
            end
            ALLOCATE: begin
                p1_stall_o = 1'b1;
                if (mem_enable_o && mem_ack_i) begin
                    fill_we = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            victim_q     <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
        end else begin
            state_q <= state_n;
            if (miss) begin
                victim_q     <= victim_sel;
                mem_enable_o <= 1'b1;
                if (state_n == WRITEBACK) begin
                    mem_write_o <= 1'b1;
                    mem_addr_o  <= ADDR_W'(line_addr(64'(way_tag[victim_sel]), 64'(req_index),
                                                     OFFSET_W, INDEX_W));
                    mem_data_o  <= way_line[victim_sel];
                end else begin
                    mem_write_o <= 1'b0;
                    mem_addr_o  <= ADDR_W'(line_addr(64'(req_tag), 64'(req_index),
                                                     OFFSET_W, INDEX_W));
                end
            end else if (mem_enable_o && mem_ack_i) begin
                // Write-back done: keep enable high and turn the request into the fill.
                if (state_q == WRITEBACK) begin
                    mem_write_o <= 1'b0;
                    mem_addr_o  <= ADDR_W'(line_addr(64'(req_tag), 64'(req_index),
                                                     OFFSET_W, INDEX_W));
                end else begin
                    mem_enable_o <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int s = 0; s < SETS; s++) begin
                rr_q[s] <= '0;
            end
        end else if (fill_we) begin
            rr_q[req_index] <= (rr_q[req_index] == WAY_W'(WAYS - 1)) ? '0 :
                               rr_q[req_index] + WAY_W'(1);
        end
    end

endmodule

// File: tb/tb_dcache_assoc_ctrl.sv
// tb/tb_dcache_assoc_ctrl.sv - randomized self-checking bench for dcache_assoc_ctrl
module tb_dcache_assoc_ctrl;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;
    localparam int LINE_W = 256;
    localparam int SETS   = 16;
    localparam int WAYS   = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [31:0]       p1_addr_i;
    logic [31:0]       p1_data_i;
    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;
    logic [LINE_W-1:0] mem_data_i = '0;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_o;
    logic [31:0]       mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;

    logic ack_model = 1'b0;
    logic ack_spur;
    assign mem_ack_i = ack_model | ack_spur;

    int n_checks = 0;
    int n_errors = 0;

    dcache_assoc_ctrl #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W),
        .LINE_W (LINE_W),
        .SETS   (SETS),
        .WAYS   (WAYS)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F1E;
    endfunction

    // Backing memory: acks the 4th cycle enable is seen high (3 cycles after it rises).
    logic [LINE_W-1:0] backing [logic [31:0]];
    int          mem_cnt = 0;
    int          wb_count = 0;
    int          fill_count = 0;
    int          wr_cycles = 0;
    logic [31:0] last_wb_addr = '0;
    logic [31:0] last_fill_addr = '0;

    function automatic logic [LINE_W-1:0] bk_line(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        if (backing.exists(la)) return backing[la];
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = init_word(la + 32'(4 * i));
        return l;
    endfunction

    always @(negedge clk_i) begin
        ack_model = 1'b0;
        if (rst_i || !mem_enable_o) begin
            mem_cnt = 0;
        end else begin
            if (mem_write_o) wr_cycles++;
            mem_cnt++;
            if (mem_cnt == 4) begin
                mem_cnt   = 0;
                ack_model = 1'b1;
                if (mem_write_o) begin
                    backing[mem_addr_o] = mem_data_o;
                    wb_count++;
                    last_wb_addr = mem_addr_o;
                end else begin
                    mem_data_i = bk_line(mem_addr_o);
                    fill_count++;
                    last_fill_addr = mem_addr_o;
                end
            end
        end
    end

    // Reference: architectural word values plus the cache directory contents.
    logic [31:0] arch      [logic [31:0]];
    logic [31:0] committed [logic [31:0]];
    bit          m_valid [SETS][WAYS];
    bit          m_dirty [SETS][WAYS];
    int          m_tag   [SETS][WAYS];
    int          m_rr    [SETS];

    function automatic logic [31:0] arch_rd(input logic [31:0] a);
        if (arch.exists(a)) return arch[a];
        return init_word(a);
    endfunction

    task automatic model_reset();
        logic [31:0] la;
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                if (m_valid[s][w] && m_dirty[s][w]) begin
                    la = 32'((m_tag[s][w] << 9) | (s << 5));
                    for (int i = 0; i < 8; i++) begin
                        if (committed.exists(la + 32'(4 * i)))
                            arch[la + 32'(4 * i)] = committed[la + 32'(4 * i)];
                        else
                            arch.delete(la + 32'(4 * i));
                    end
                end
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
            end
            m_rr[s] = 0;
        end
    endtask

    task automatic access(input logic [31:0] a, input bit rd, input bit wr,
                          input logic [31:0] wd, output int got_stall, output logic [31:0] got_d);
        int set, tag, way, exp_stall, cyc, wb0, fill0, wrc0;
        bit exp_wb, exp_hit;
        logic [31:0] exp_wb_addr, exp_data, la;
        set = int'((a >> 5) & 32'hF);
        tag = int'(a >> 9);
        way = -1;
        exp_wb = 1'b0;
        exp_wb_addr = '0;
        for (int w = 0; w < WAYS; w++)
            if (m_valid[set][w] && m_tag[set][w] == tag) way = w;
        exp_hit = (way >= 0);
        if (!exp_hit) begin
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[set][w]) way = w;
            if (way < 0) way = m_rr[set];
            exp_wb = m_valid[set][way] && m_dirty[set][way];
            if (exp_wb) begin
                exp_wb_addr = 32'((m_tag[set][way] << 9) | (set << 5));
                for (int i = 0; i < 8; i++) begin
                    la = exp_wb_addr + 32'(4 * i);
                    if (arch.exists(la)) committed[la] = arch[la];
                end
            end
            m_valid[set][way] = 1'b1;
            m_dirty[set][way] = 1'b0;
            m_tag[set][way]   = tag;
            m_rr[set]         = (m_rr[set] + 1) % WAYS;
        end
        exp_stall = exp_hit ? 0 : (exp_wb ? 9 : 5);
        exp_data  = arch_rd(a);
        if (wr) begin
            m_dirty[set][way] = 1'b1;
            arch[a] = wd;
        end

        @(negedge clk_i);
        p1_addr_i     = a;
        p1_data_i     = wd;
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        #1;
        wb0  = wb_count;
        fill0 = fill_count;
        wrc0 = wr_cycles;
        cyc  = 0;
        while (p1_stall_o && cyc < 40) begin
            cyc++;
            @(negedge clk_i);
            #1;
        end
        got_stall = cyc;
        got_d     = p1_data_o;
        check("stall_cycles", 64'(cyc), 64'(exp_stall));
        if (rd && !wr) check("load_data", p1_data_o, exp_data);
        check("writeback_count", 64'(wb_count - wb0), 64'(exp_wb));
        check("write_cycles", 64'(wr_cycles - wrc0), exp_wb ? 64'd4 : 64'd0);
        if (exp_wb) check("writeback_addr", last_wb_addr, exp_wb_addr);
        check("fill_count", 64'(fill_count - fill0), exp_hit ? 64'd0 : 64'd1);
        if (!exp_hit) check("fill_addr", last_fill_addr, {a[31:5], 5'b0});
        @(posedge clk_i);
        #1;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
    endtask

    initial begin
        int          s;
        logic [31:0] d;
        logic [LINE_W-1:0] l;
        logic [31:0] a;
        int          op;

        rst_i = 1'b1;
        ack_spur = 1'b0;
        p1_addr_i = '0;
        p1_data_i = '0;
        p1_MemRead_i = 1'b0;
        p1_MemWrite_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        check("reset_enable", mem_enable_o, 1'b0);
        check("reset_write", mem_write_o, 1'b0);
        check("reset_addr", mem_addr_o, 32'd0);
        check("reset_mem_data", 64'(mem_data_o), 64'd0);
        check("reset_stall", p1_stall_o, 1'b0);
        check("reset_data", p1_data_o, 32'd0);
        rst_i = 1'b0;

        access(32'h40, 1'b1, 1'b0, '0, s, d);
        check("cold_miss_stall", 64'(s), 64'd5);
        check("cold_miss_data", d, init_word(32'h40));
        access(32'h40, 1'b1, 1'b0, '0, s, d);
        check("hit_stall", 64'(s), 64'd0);
        access(32'h44, 1'b0, 1'b1, 32'hDEAD_BEEF, s, d);
        access(32'h44, 1'b1, 1'b0, '0, s, d);
        check("store_readback", d, 32'hDEAD_BEEF);
        access(32'h240, 1'b1, 1'b0, '0, s, d);
        check("second_way_fill", 64'(s), 64'd5);
        access(32'h440, 1'b1, 1'b0, '0, s, d);
        check("dirty_evict_stall", 64'(s), 64'd9);
        l = bk_line(32'h40);
        check("writeback_word", l[63:32], 32'hDEAD_BEEF);
        access(32'h40, 1'b1, 1'b0, '0, s, d);
        check("clean_evict_stall", 64'(s), 64'd5);
        access(32'h44, 1'b1, 1'b0, '0, s, d);
        check("refetched_word", d, 32'hDEAD_BEEF);

        @(negedge clk_i);
        ack_spur = 1'b1;
        @(negedge clk_i);
        ack_spur = 1'b0;
        #1;
        check("spurious_ack_enable", mem_enable_o, 1'b0);
        check("spurious_ack_stall", p1_stall_o, 1'b0);
        access(32'h48, 1'b1, 1'b1, 32'h1234_5678, s, d);
        check("rw_both_stall", 64'(s), 64'd0);
        access(32'h48, 1'b1, 1'b0, '0, s, d);
        check("rw_both_is_store", d, 32'h1234_5678);

        @(negedge clk_i);
        p1_addr_i    = 32'h0000_0A60;
        p1_MemRead_i = 1'b1;
        #1;
        check("rst_test_miss", p1_stall_o, 1'b1);
        @(negedge clk_i);
        @(negedge clk_i);
        check("alloc_active", {mem_enable_o, mem_write_o}, 2'b10);
        rst_i = 1'b1;
        p1_MemRead_i = 1'b0;
        @(negedge clk_i);
        #1;
        check("rst_enable_drop", mem_enable_o, 1'b0);
        check("rst_stall_drop", p1_stall_o, 1'b0);
        rst_i = 1'b0;
        ack_spur = 1'b1;
        model_reset();
        @(negedge clk_i);
        ack_spur = 1'b0;
        #1;
        check("late_ack_enable", mem_enable_o, 1'b0);
        check("late_ack_stall", p1_stall_o, 1'b0);
        access(32'h40, 1'b1, 1'b0, '0, s, d);
        check("post_reset_miss", 64'(s), 64'd5);
        access(32'h48, 1'b1, 1'b0, '0, s, d);

        for (int n = 0; n < 300; n++) begin
            a  = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5) |
                 ($urandom_range(0, 7) << 2);
            op = int'($urandom_range(0, 3));
            access(a, op != 2, op >= 2, $urandom, s, d);
            repeat ($urandom_range(0, 2)) @(posedge clk_i);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
